// File: rtl/regfile_pkg.sv
// regfile_pkg: shared sizes, zero-register index and address type for the register file
package regfile_pkg;
    localparam int NUM_REGS = 32;
    localparam int ADDR_W = 5;
    localparam logic [ADDR_W-1:0] XZR_IDX = 5'd31;
    typedef logic [ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/regfile_32x64_if.sv
// regfile_32x64_if: write port and two read ports of the register file
interface regfile_32x64_if #(parameter int WIDTH = 64);
    import regfile_pkg::*;
    logic             wr_en;
    reg_addr_t        wr_addr;
    logic [WIDTH-1:0] wr_data;
    reg_addr_t        rd_addr1;
    reg_addr_t        rd_addr2;
    logic [WIDTH-1:0] rd_data1;
    logic [WIDTH-1:0] rd_data2;
    modport master(output wr_en, wr_addr, wr_data, rd_addr1, rd_addr2, input rd_data1, rd_data2);
    modport slave(input wr_en, wr_addr, wr_data, rd_addr1, rd_addr2, output rd_data1, rd_data2);
endinterface

// File: rtl/regfile_32x64_decoder.sv
// decoder5_32: one-hot 5-to-32 write-enable decoder, all zero when en is low
module decoder5_32
    import regfile_pkg::*;
(
    input  reg_addr_t           sel,
    input  logic                en,
    output logic [NUM_REGS-1:0] d
);
    always_comb d = en ? ({{(NUM_REGS-1){1'b0}}, 1'b1} << sel) : '0;
endmodule

// File: rtl/regfile_32x64.sv
// regfile_32x64: 31 stored registers plus hard-wired zero at index 31, two comb read ports
module regfile_32x64
    import regfile_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter bit BYPASS = 1'b1
) (
    input logic             clk,
    input logic             reset_n,
    regfile_32x64_if.slave  bus
);
    logic [NUM_REGS-1:0]            w_we;
    logic [NUM_REGS-1:0][WIDTH-1:0] w_regs;
    logic                           w_unused;
    logic                           w_hit1;
    logic                           w_hit2;

    function automatic logic [WIDTH-1:0] mux32(input logic [NUM_REGS-1:0][WIDTH-1:0] regs, input reg_addr_t sel);
        return regs[sel];
    endfunction

    decoder5_32 u_dec (
        .sel (bus.wr_addr),
        .en  (bus.wr_en),
        .d   (w_we)
    );

    // index 31 has no storage, so its enable goes nowhere
    assign w_unused = w_we[XZR_IDX];

    for (genvar i = 0; i < NUM_REGS - 1; i++) begin : g_reg
        logic [WIDTH-1:0] r_q;
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) r_q <= '0;
            else if (w_we[i]) r_q <= bus.wr_data;
        end
        assign w_regs[i] = r_q;
    end
    assign w_regs[XZR_IDX] = '0;

    // forwarding is suppressed in reset so outputs read zero regardless of wr_*
    assign w_hit1 = BYPASS && reset_n && bus.wr_en && (bus.wr_addr == bus.rd_addr1) && (bus.rd_addr1 != XZR_IDX);
    assign w_hit2 = BYPASS && reset_n && bus.wr_en && (bus.wr_addr == bus.rd_addr2) && (bus.rd_addr2 != XZR_IDX);

    assign bus.rd_data1 = w_hit1 ? bus.wr_data : mux32(w_regs, bus.rd_addr1);
    assign bus.rd_data2 = w_hit2 ? bus.wr_data : mux32(w_regs, bus.rd_addr2);
endmodule

// File: tb/tb_regfile_32x64.sv
// tb_regfile_32x64: directed vectors against bypassing and non-bypassing register files
module tb_regfile_32x64;
    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [63:0] wr_data;
    logic [4:0]  rd_addr1;
    logic [4:0]  rd_addr2;
    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] m [32];

    regfile_32x64_if #(.WIDTH(64)) bus_b ();
    regfile_32x64_if #(.WIDTH(64)) bus_n ();

    assign bus_b.wr_en = wr_en;
    assign bus_b.wr_addr = wr_addr;
    assign bus_b.wr_data = wr_data;
    assign bus_b.rd_addr1 = rd_addr1;
    assign bus_b.rd_addr2 = rd_addr2;
    assign bus_n.wr_en = wr_en;
    assign bus_n.wr_addr = wr_addr;
    assign bus_n.wr_data = wr_data;
    assign bus_n.rd_addr1 = rd_addr1;
    assign bus_n.rd_addr2 = rd_addr2;

    regfile_32x64 #(.WIDTH(64), .BYPASS(1'b1)) dut_b (.clk(clk), .reset_n(rst_n), .bus(bus_b));
    regfile_32x64 #(.WIDTH(64), .BYPASS(1'b0)) dut_n (.clk(clk), .reset_n(rst_n), .bus(bus_n));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) for (int k = 0; k < 32; k++) m[k] <= '0;
        else if (wr_en && wr_addr != 5'd31) m[wr_addr] <= wr_data;
    end

    function automatic logic [63:0] exp_rd(input logic [4:0] a, input bit byp);
        if (!rst_n || a == 5'd31) return 64'd0;
        if (byp && wr_en && wr_addr == a) return wr_data;
        return m[a];
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("model_b_rd1", bus_b.rd_data1, exp_rd(rd_addr1, 1'b1));
        chk("model_b_rd2", bus_b.rd_data2, exp_rd(rd_addr2, 1'b1));
        chk("model_n_rd1", bus_n.rd_data1, exp_rd(rd_addr1, 1'b0));
        chk("model_n_rd2", bus_n.rd_data2, exp_rd(rd_addr2, 1'b0));
    end

    task automatic set_in(input logic we, input logic [4:0] wa, input logic [63:0] wd, input logic [4:0] a1, input logic [4:0] a2);
        wr_en = we;
        wr_addr = wa;
        wr_data = wd;
        rd_addr1 = a1;
        rd_addr2 = a2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(1'b1, 5'd5, 64'hDEAD, 5'd5, 5'd5);
        tick();
        tick();
        chk("reset_hold_b", bus_b.rd_data1, 64'd0);
        chk("reset_hold_n", bus_n.rd_data1, 64'd0);
        rst_n = 1'b1;
        set_in(1'b0, 5'd0, 64'd0, 5'd0, 5'd0);
        for (int i = 0; i < 32; i++) begin
            rd_addr1 = 5'(i);
            rd_addr2 = 5'(31 - i);
            #1;
            chk("post_reset_b1", bus_b.rd_data1, 64'd0);
            chk("post_reset_b2", bus_b.rd_data2, 64'd0);
            chk("post_reset_n1", bus_n.rd_data1, 64'd0);
        end
        tick();
        for (int i = 0; i < 31; i++) begin
            set_in(1'b1, 5'(i), 64'(i) * 64'h0101_0101, 5'(i), 5'(i));
            tick();
        end
        set_in(1'b1, 5'd31, 64'hFFFF, 5'd31, 5'd31);
        tick();
        set_in(1'b0, 5'd0, 64'd0, 5'd0, 5'd0);
        for (int i = 0; i < 32; i++) begin
            rd_addr1 = 5'(i);
            rd_addr2 = 5'(i);
            #1;
            chk("wr_all_b1", bus_b.rd_data1, i == 31 ? 64'd0 : 64'(i) * 64'h0101_0101);
            chk("wr_all_b2", bus_b.rd_data2, i == 31 ? 64'd0 : 64'(i) * 64'h0101_0101);
            chk("wr_all_n1", bus_n.rd_data1, i == 31 ? 64'd0 : 64'(i) * 64'h0101_0101);
        end
        chk("pin_reg30", bus_n.rd_data2, 64'd0);
        rd_addr2 = 5'd30;
        #1;
        chk("pin_reg30", bus_n.rd_data2, 64'h1E1E_1E1E);
        tick();
        set_in(1'b1, 5'd7, 64'h11, 5'd0, 5'd0);
        tick();
        set_in(1'b1, 5'd7, 64'h22, 5'd7, 5'd7);
        #1;
        chk("bypass_b1", bus_b.rd_data1, 64'h22);
        chk("bypass_b2", bus_b.rd_data2, 64'h22);
        chk("nobypass_pre_n1", bus_n.rd_data1, 64'h11);
        chk("nobypass_pre_n2", bus_n.rd_data2, 64'h11);
        tick();
        wr_en = 1'b0;
        #1;
        chk("nobypass_post_n1", bus_n.rd_data1, 64'h22);
        set_in(1'b1, 5'd4, 64'h77, 5'd4, 5'd5);
        #1;
        chk("bypass_indep_b1", bus_b.rd_data1, 64'h77);
        chk("bypass_indep_b2", bus_b.rd_data2, 64'h0505_0505);
        chk("bypass_indep_n1", bus_n.rd_data1, 64'h0404_0404);
        tick();
        set_in(1'b1, 5'd31, 64'h55, 5'd31, 5'd31);
        #1;
        chk("xzr_bypass_b1", bus_b.rd_data1, 64'd0);
        chk("xzr_bypass_b2", bus_b.rd_data2, 64'd0);
        tick();
        chk("xzr_after_b1", bus_b.rd_data1, 64'd0);
        set_in(1'b1, 5'd12, 64'd1, 5'd12, 5'd12);
        tick();
        set_in(1'b1, 5'd12, 64'd2, 5'd12, 5'd12);
        tick();
        wr_en = 1'b0;
        #1;
        chk("back_to_back_n1", bus_n.rd_data1, 64'd2);
        set_in(1'b1, 5'd3, 64'hA5, 5'd3, 5'd3);
        tick();
        wr_en = 1'b0;
        #1;
        chk("load_reg3_n1", bus_n.rd_data1, 64'hA5);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_b1", bus_b.rd_data1, 64'd0);
        chk("async_rst_n1", bus_n.rd_data1, 64'd0);
        chk("async_rst_n2", bus_n.rd_data2, 64'd0);
        #1;
        rst_n = 1'b1;
        #0.5;
        chk("async_rel_n1", bus_n.rd_data1, 64'd0);
        set_in(1'b1, 5'd9, 64'h99, 5'd9, 5'd0);
        tick();
        wr_en = 1'b0;
        #1;
        chk("first_write_n1", bus_n.rd_data1, 64'h99);
        for (int i = 0; i < 31; i++) begin
            set_in(1'b1, 5'(i), 64'hC0DE_0000_0000_0000 | 64'(i), 5'd0, 5'd0);
            tick();
        end
        for (int i = 0; i < 32; i++) begin
            set_in(1'b0, 5'(i), {$urandom, $urandom}, 5'(i), 5'(31 - i));
            tick();
        end
        set_in(1'b0, 5'bx, 64'hBAD0_BAD0_BAD0_BAD0, 5'd0, 5'd0);
        tick();
        for (int i = 0; i < 32; i++) begin
            rd_addr1 = 5'(i);
            rd_addr2 = 5'(i);
            #1;
            chk("we0_sweep_n1", bus_n.rd_data1, i == 31 ? 64'd0 : 64'hC0DE_0000_0000_0000 | 64'(i));
            chk("we0_sweep_b2", bus_b.rd_data2, i == 31 ? 64'd0 : 64'hC0DE_0000_0000_0000 | 64'(i));
        end
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
